fetch_stage: RTL and testbench

// - Instruction-fetch stage: owns the PC register, drives the word address into the

---
 rtl/fetch_stage_if.sv | 26 ++
 rtl/fetch_stage.sv | 85 ++++++++
 tb/tb_fetch_stage.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage and its neighbours: hazard/redirect control,
// the instruction-memory read port, and the IF/ID pipeline register outputs.
interface fetch_stage_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush_d;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic [31:0] pc_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc8_d;
  logic        valid_d;
  logic        exc_adel_d;

  modport master (
    input  stall, redirect, redirect_pc, flush_d, imem_rd,
    output imem_addr, pc_f, instr_d, pc_d, pc8_d, valid_d, exc_adel_d
  );

  modport slave (
    output stall, redirect, redirect_pc, flush_d, imem_rd,
    input  imem_addr, pc_f, instr_d, pc_d, pc8_d, valid_d, exc_adel_d
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, combinational imem address, and IF/ID register
// with stall, redirect, flush and fetch-address-error (AdEL) handling.
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 1024,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);

  // Window end computed in 33 bits so a window touching the top of memory cannot wrap.
  localparam logic [32:0] PC_LIMIT = {1'b0, PC_RESET} + (33'(IM_WORDS) << 2);

  logic [31:0] f_pc_q,       f_pc_d;
  logic [31:0] id_instr_q,   id_instr_d;
  logic [31:0] id_pc_q,      id_pc_d;
  logic [31:0] id_pc8_q,     id_pc8_d;
  logic        id_valid_q,   id_valid_d;
  logic        id_exc_q,     id_exc_d;
  logic        fetch_err;

  assign fetch_err = (f_pc_q[1:0] != 2'b00)
                   || (f_pc_q < PC_RESET)
                   || ({1'b0, f_pc_q} >= PC_LIMIT);

  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path can infer a latch.
    f_pc_d     = f_pc_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    id_pc8_d   = id_pc8_q;
    id_valid_d = id_valid_q;
    id_exc_d   = id_exc_q;

    // A stalled redirect is dropped; its source is stalled too and will reassert it.
    if (!bus.stall) begin
      if (bus.redirect) f_pc_d = bus.redirect_pc;
      else              f_pc_d = f_pc_q + 32'd4;
    end

    if (bus.flush_d) begin
      id_instr_d = NOP_WORD;
      id_pc_d    = f_pc_q;
      id_pc8_d   = f_pc_q + 32'd8;
      id_valid_d = 1'b0;
      id_exc_d   = 1'b0;
    end else if (!bus.stall) begin
      id_pc_d    = f_pc_q;
      id_pc8_d   = f_pc_q + 32'd8;
      id_valid_d = 1'b1;
      id_exc_d   = fetch_err;
      id_instr_d = fetch_err ? NOP_WORD : bus.imem_rd;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_pc_q     <= PC_RESET;
      id_instr_q <= NOP_WORD;
      id_pc_q    <= PC_RESET;
      id_pc8_q   <= PC_RESET + 32'd8;
      id_valid_q <= 1'b0;
      id_exc_q   <= 1'b0;
    end else begin
      f_pc_q     <= f_pc_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      id_pc8_q   <= id_pc8_d;
      id_valid_q <= id_valid_d;
      id_exc_q   <= id_exc_d;
    end
  end

  assign bus.imem_addr  = f_pc_q;
  assign bus.pc_f       = f_pc_q;
  assign bus.instr_d    = id_instr_q;
  assign bus.pc_d       = id_pc_q;
  assign bus.pc8_d      = id_pc8_q;
  assign bus.valid_d    = id_valid_q;
  assign bus.exc_adel_d = id_exc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a reference model pushes the expected state per
// cycle into a scoreboard queue, which is popped and compared after each rising edge.
module tb_fetch_stage;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam int unsigned IM_WORDS = 1024;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc_f;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] pc8;
    logic        valid;
    logic        exc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  fetch_stage_if bus ();
  logic [31:0] imem [IM_WORDS];

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb_q[$];

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pcd, m_pc8;
  logic        m_valid, m_exc;

  fetch_stage #(.PC_RESET(PC_RESET), .IM_WORDS(IM_WORDS), .NOP_WORD(NOP_WORD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.imem_rd = imem[bus.imem_addr[11:2]];

  function automatic logic [31:0] mem_word(int unsigned idx);
    return 32'h3C01_0001 + idx * 32'h0101_0011;
  endfunction

  function automatic logic model_err(logic [31:0] pc);
    longint unsigned p;
    p = longint'(pc);
    return (pc[1:0] != 2'b00) || (p < 64'h3000) || (p >= 64'h3000 + 64'd4096);
  endfunction

  task automatic model_reset();
    m_pc = PC_RESET; m_instr = NOP_WORD; m_pcd = PC_RESET; m_pc8 = PC_RESET + 32'd8;
    m_valid = 1'b0; m_exc = 1'b0;
  endtask

  task automatic check_now(string name, exp_t e);
    n_checks += 6;
    if (bus.pc_f !== e.pc_f)       begin n_fail++; $display("FAIL %s pc_f: got %h want %h", name, bus.pc_f, e.pc_f); end
    if (bus.instr_d !== e.instr)   begin n_fail++; $display("FAIL %s instr_d: got %h want %h", name, bus.instr_d, e.instr); end
    if (bus.pc_d !== e.pcd)        begin n_fail++; $display("FAIL %s pc_d: got %h want %h", name, bus.pc_d, e.pcd); end
    if (bus.pc8_d !== e.pc8)       begin n_fail++; $display("FAIL %s pc8_d: got %h want %h", name, bus.pc8_d, e.pc8); end
    if (bus.valid_d !== e.valid)   begin n_fail++; $display("FAIL %s valid_d: got %b want %b", name, bus.valid_d, e.valid); end
    if (bus.exc_adel_d !== e.exc)  begin n_fail++; $display("FAIL %s exc_adel_d: got %b want %b", name, bus.exc_adel_d, e.exc); end
  endtask

  // Drive one cycle of stimulus, advance the model, push the expectation, clock, then pop.
  task automatic cycle(string name, logic st, logic rd, logic [31:0] rpc, logic fl);
    exp_t e;
    logic [31:0] pc_old;
    bus.stall = st; bus.redirect = rd; bus.redirect_pc = rpc; bus.flush_d = fl;
    pc_old = m_pc;
    if (fl) begin
      m_instr = NOP_WORD; m_pcd = pc_old; m_pc8 = pc_old + 32'd8; m_valid = 1'b0; m_exc = 1'b0;
    end else if (!st) begin
      m_pcd = pc_old; m_pc8 = pc_old + 32'd8; m_valid = 1'b1;
      m_exc = model_err(pc_old);
      m_instr = m_exc ? NOP_WORD : mem_word(int'(pc_old[11:2]));
    end
    if (!st) m_pc = rd ? rpc : pc_old + 32'd4;
    e = '{m_pc, m_instr, m_pcd, m_pc8, m_valid, m_exc};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++; $display("FAIL %s scoreboard: got empty want entry", name);
    end else begin
      e = sb_q.pop_front();
      check_now(name, e);
    end
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b0;
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0; bus.flush_d = 1'b0;
    model_reset();
    #12;
    e = '{PC_RESET, NOP_WORD, PC_RESET, PC_RESET + 32'd8, 1'b0, 1'b0};
    check_now("reset_state", e);
    reset = 1'b1;
    cycle("first_fetch", 0, 0, '0, 0);
    if (bus.instr_d !== 32'h3C01_0001) begin
      n_fail++; $display("FAIL first_word: got %h want %h", bus.instr_d, 32'h3C01_0001);
    end
    n_checks++;
  endtask

  task automatic test_stall();
    cycle("to_3008", 0, 0, '0, 0);
    for (int i = 0; i < 3; i++) cycle("stall_hold", 1, 0, '0, 0);
    cycle("stall_release", 0, 0, '0, 0);
  endtask

  task automatic test_redirect();
    cycle("to_3010", 0, 0, '0, 0);
    cycle("redirect_delay_slot", 0, 1, 32'h0000_3100, 0);
    cycle("redirect_target", 0, 0, '0, 0);
  endtask

  task automatic test_stall_flush();
    cycle("redir_3020", 0, 1, 32'h0000_3020, 0);
    cycle("stall_redir_flush", 1, 1, 32'h0000_3200, 1);
    cycle("refetch_3020", 0, 0, '0, 0);
    cycle("flush_only", 0, 0, '0, 1);
  endtask

  task automatic test_fetch_err();
    cycle("redir_misaligned", 0, 1, 32'h0000_3102, 0);
    cycle("misaligned_err_redir_4000", 0, 1, 32'h0000_4000, 0);
    cycle("above_window_err", 0, 0, '0, 0);
    cycle("redir_top_word", 0, 1, 32'h0000_3FFC, 0);
    cycle("top_word_ok", 0, 1, 32'h0000_2FFC, 0);
    cycle("below_window_err", 0, 1, 32'hFFFF_FFFC, 0);
    cycle("max_addr_err_wrap", 0, 0, '0, 0);
    cycle("wrapped_zero_err", 0, 0, '0, 0);
  endtask

  task automatic test_async_reset();
    exp_t e;
    cycle("redir_3040", 0, 1, 32'h0000_3040, 0);
    cycle("at_3040", 1, 0, '0, 0);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    e = '{PC_RESET, NOP_WORD, PC_RESET, PC_RESET + 32'd8, 1'b0, 1'b0};
    check_now("async_reset", e);
    #3;
    reset = 1'b1;
    cycle("restart_3000", 0, 0, '0, 0);
    cycle("restart_3004", 0, 0, '0, 0);
  endtask

  task automatic test_back_to_back();
    logic st, rd, fl;
    logic [31:0] rpc;
    for (int i = 0; i < 300; i++) begin
      st = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 6) == 0);
      case ($urandom_range(0, 9))
        0:       rpc = 32'h0000_2FFC;
        1:       rpc = 32'h0000_3FF8;
        2:       rpc = 32'h0000_3000 + 32'($urandom_range(0, 4095));
        default: rpc = 32'h0000_3000 + (32'($urandom_range(0, 1023)) << 2);
      endcase
      cycle("random", st, rd, rpc, fl);
    end
  endtask

  initial begin
    for (int i = 0; i < int'(IM_WORDS); i++) imem[i] = mem_word(i);
    test_reset();
    test_stall();
    test_redirect();
    test_stall_flush();
    test_fetch_err();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
